// File: rtl/lane_tag_arbiter.sv
// Round-robin arbiter granting bursts of up to BURST beats to one of K lanes and
// emitting each accepted index tagged with its lane number in the LSBs.
module lane_tag_arbiter #(
    parameter int K     = 4,
    parameter int SIZE  = 16,
    parameter int BURST = 2,
    localparam int IW   = $clog2(SIZE),
    localparam int TW   = $clog2(K),
    localparam int OW   = IW + TW,
    localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [K-1:0]    req_valid,
    input  logic [K*IW-1:0] req_idx,
    output logic [K-1:0]    req_ready,
    output logic            out_valid,
    output logic [OW-1:0]   out_data,
    input  logic            out_ready,
    output logic            dbg_state_o,
    output logic [TW-1:0]   dbg_lock_o,
    output logic [TW-1:0]   dbg_ptr_o,
    output logic [CW-1:0]   dbg_cnt_o
);

    // Handshake: a lane beat transfers when req_valid[i] && req_ready[i]; the output
    // word transfers when out_valid && out_ready, and out_data is stable until then.
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   lock_q, lock_d;
    logic [TW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q;
    logic [OW-1:0]   out_data_q;

    logic            slot_free;
    logic            accept;
    logic [TW-1:0]   pick;
    logic            found;
    int              cand;
    logic [IW-1:0]   sel_idx;
    logic [TW-1:0]   lock_next;

    assign slot_free = !out_valid_q || out_ready;
    assign lock_next = (lock_q == TW'(K - 1)) ? '0 : lock_q + TW'(1);

    // First valid lane at or after ptr, wrapping modulo K.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        cand  = 0;
        for (int j = 0; j < K; j++) begin
            cand = int'(ptr_q) + j;
            if (cand >= K) cand = cand - K;
            if (!found && req_valid[cand]) begin
                pick  = TW'(cand);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < K; i++) begin
            if (lock_q == TW'(i)) sel_idx = req_idx[i*IW +: IW];
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == GRANT && req_valid[lock_q] && slot_free) req_ready[lock_q] = 1'b1;
    end

    assign accept = |req_ready;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    lock_d  = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (slot_free) begin
                    if (!req_valid[lock_q] || cnt_q == CW'(BURST - 1)) begin
                        state_d = IDLE;
                        ptr_d   = lock_next;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_q      <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= {sel_idx, lock_q};
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign dbg_state_o = state_q;
    assign dbg_lock_o  = lock_q;
    assign dbg_ptr_o   = ptr_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: doc/lane_tag_arbiter.md
LANE_TAG_ARBITER -- requirements
Module: lane_tag_arbiter

Interface
REQ-001 Parameter K, default 4: number of requesting lanes; SHALL be >= 2.
REQ-002 Parameter SIZE, default 16: index range; IW = $clog2(SIZE) bits per index.
REQ-003 Parameter BURST, default 2: maximum consecutive beats granted to one lane; SHALL be >= 1.
REQ-004 Derived TW = $clog2(K), the lane tag width; OW = IW + TW, the output word width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  K  bit i: lane i presents an index.
REQ-008 req_idx  input  K*IW  lane i index at bits [IW*(i+1)-1 : IW*i].
REQ-009 req_ready  output  K  bit i: lane i beat accepted this cycle.
REQ-010 out_valid  output  1  out_data holds a valid tagged word.
REQ-011 out_data  output  OW  tagged word {index[IW-1:0], lane[TW-1:0]}, with the lane tag in the LSBs.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid=1.

Function
REQ-013 FSM states SHALL be IDLE (no lane locked) and GRANT (lane `lock` locked), with a beat counter `cnt` (0..BURST-1) and a round-robin pointer `ptr` (0..K-1).
REQ-014 slot_free SHALL equal (!out_valid || out_ready).
REQ-015 In IDLE with any req_valid set, the FSM SHALL lock the first valid lane searching ptr, ptr+1, ... mod K, go to GRANT next cycle, and clear cnt to 0.
REQ-016 In IDLE with no req_valid set, the FSM SHALL remain in IDLE; req_ready SHALL be 0 in IDLE.
REQ-017 req_ready[i] SHALL be combinational and equal (state==GRANT && lock==i && req_valid[i] && slot_free); at most one bit is set per cycle.
REQ-018 Accept is defined as a cycle in which any req_ready bit is 1; on accept, out_data <= {req_idx[lock], lock[TW-1:0]} and out_valid <= 1.
REQ-019 Without an accept, out_valid SHALL clear on out_ready=1, and out_data SHALL hold its value.
REQ-020 On accept with cnt == BURST-1, the FSM SHALL go to IDLE with ptr <= (lock+1) mod K; otherwise cnt SHALL increment.
REQ-021 In GRANT with req_valid[lock]=0 and slot_free=1, the FSM SHALL go to IDLE with ptr <= (lock+1) mod K and no accept.
REQ-022 In GRANT with slot_free=0 (backpressure), the FSM SHALL hold state, cnt and lock, and out_data/out_valid SHALL be stable.
REQ-023 Latency: req_valid rising in IDLE at cycle t with slot free SHALL give req_ready at t+1 and out_valid at t+2.
REQ-024 Throughput: one accept per cycle within a burst; exactly one idle (IDLE) cycle between bursts.
REQ-025 Lane tag wrap-around: ptr and tag SHALL wrap modulo K; for K not a power of two, ptr SHALL never exceed K-1.
REQ-026 Changes to req_valid of non-locked lanes SHALL have no effect during GRANT.

Reset
REQ-027 While rst=1, regardless of clk, the FSM SHALL be IDLE with ptr=0, lock=0, cnt=0, out_valid=0, out_data=0, and req_ready=0.
REQ-028 Reset during GRANT or with out_valid=1 SHALL discard the in-flight word; the first grant after reset SHALL search from lane 0.

Verification (K=4, SIZE=16, BURST=2)
REQ-029 Assert rst mid-cycle -> out_valid=0, req_ready=4'b0000, out_data=6'h00 immediately, without waiting for a clock edge.
REQ-030 Lane 2 only, idx=5, out_ready=1 -> req_ready=4'b0100 at t+1, out_valid=1 with out_data=6'h16 at t+2, then IDLE.
REQ-031 All lanes valid continuously, out_ready=1 -> output tag sequence 0,0,-,1,1,-,2,2,-,3,3,-,0 ('-' = out_valid 0).
REQ-032 out_ready=0 for 5 cycles while out_valid=1 -> out_data constant, req_ready=0000, cnt unchanged; resumes on the next out_ready=1.
REQ-033 Lane 1 drops valid after 1 beat -> release to IDLE, ptr=2; lane 2 is granted next if valid, skipping lane 1.
REQ-034 Pulse rst in GRANT(lock=3, cnt=1) -> IDLE, ptr=0; with lanes 0 and 3 valid, lane 0 is granted first.
